// File: rtl/spi_cfg_arbiter_pkg.sv
// Shared types and FMC-200A command-word layout for the SPI configuration arbiter.
package spi_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StGap
  } state_t;

  localparam int unsigned CmdWidth = 16;

  // FMC-200A command word: [15] read/not-write, [14:8] register address, [7:0] data.
  localparam int unsigned CmdRnwBit  = 15;
  localparam int unsigned CmdAddrLsb = 8;
  localparam int unsigned CmdAddrW   = 7;
  localparam int unsigned CmdDataLsb = 0;
  localparam int unsigned CmdDataW   = 8;

endpackage

// File: rtl/spi_cfg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping around.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  int unsigned pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = (int'(ptr_i) + i) % NUM_REQ;
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/spi_cfg_arbiter.sv
// Round-robin arbiter sharing one SPI config master between requesters, with an enforced
// inter-transaction idle gap and a start-to-done timeout.
module spi_cfg_arbiter
  import spi_cfg_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned CMD_W       = CmdWidth,
  parameter int unsigned GAP_CYC     = 48,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned IdxW       = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*CMD_W-1:0] i_req_cmd,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [NUM_REQ-1:0]       o_req_done,
  output logic [NUM_REQ-1:0]       o_req_err,
  output logic                     o_spi_start,
  output logic [CMD_W-1:0]         o_spi_cmd,
  input  logic                     i_spi_done,
  output logic                     o_busy,
  output logic [IdxW-1:0]          o_grant
);

  localparam int unsigned ToW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GapW = $clog2(GAP_CYC + 1);

  state_t             state_q, state_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [ToW-1:0]     to_cnt_q, to_cnt_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;
  logic               accept;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_i(i_req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  // Ready is gated by reset so nothing can be accepted while the block is held in reset.
  assign o_req_ready = (i_rst_n && state_q == StIdle) ? pick_gnt : '0;
  assign accept      = i_rst_n && (state_q == StIdle) && pick_any;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cmd_d     = cmd_q;
    start_d   = 1'b0;
    done_d    = '0;
    err_d     = '0;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cmd_d    = i_req_cmd[int'(pick_idx)*CMD_W +: CMD_W];
          grant_d  = pick_idx;
          rr_ptr_d = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          start_d  = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        to_cnt_d = '0;
        state_d  = StWaitDone;
      end
      StWaitDone: begin
        // Done takes priority over a coincident timeout.
        if (i_spi_done) begin
          done_d[grant_q] = 1'b1;
          gap_cnt_d       = '0;
          state_d         = StGap;
        end else if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
          err_d[grant_q] = 1'b1;
          gap_cnt_d      = '0;
          state_d        = StGap;
        end else if (to_cnt_q != ToW'(TIMEOUT_CYC)) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYC)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cmd_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cmd_q     <= cmd_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign o_spi_start = start_q;
  assign o_spi_cmd   = cmd_q;
  assign o_busy      = busy_q;
  assign o_grant     = grant_q;
  assign o_req_done  = done_q;
  assign o_req_err   = err_q;

endmodule
